// File: rtl/pg_port_flr_ctrl.sv
// pg_port_flr_ctrl
// Per-port FLR sequencer sitting upstream of the port gasket. A VF FLR strobe
// (VF n -> port n-1) holds that port in reset for RST_HOLD_CYCLES cycles. The
// port then waits for its traffic to drain and finally raises one FLR-complete
// strobe through a fixed-priority arbiter (lowest port index wins).
// The global PR reset only forces the port resets low; it never touches the
// FLR sequencing.
// Optional feature macro: PG_FLR_TIMEOUT_EN. When it is defined, the drain
// phase also ends after DRAIN_TIMEOUT cycles and o_drain_timeout pulses.
module pg_port_flr_ctrl #(
    parameter int PG_NUM_PORTS    = 1,
    parameter int RST_HOLD_CYCLES = 32,
    parameter int DRAIN_TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_flr_rcvd_vf,
    input  logic [10:0]             i_flr_rcvd_vf_num,
    input  logic [PG_NUM_PORTS-1:0] i_port_idle,
    input  logic                    i_pr_reset,
    output logic [PG_NUM_PORTS-1:0] o_port_rst_n,
    output logic                    o_flr_cmpl_vld,
    output logic [10:0]             o_flr_cmpl_vf_num,
    output logic                    o_flr_busy,
    output logic                    o_flr_err,
    output logic                    o_drain_timeout
);

    localparam int                HOLD_W       = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX     = HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [10:0]       NUM_PORTS_VF = 11'(PG_NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_CMPL   = 2'd3
    } flr_state_t;

    flr_state_t              state     [PG_NUM_PORTS];
    flr_state_t              state_nxt [PG_NUM_PORTS];
    logic [HOLD_W-1:0]       hold_cnt  [PG_NUM_PORTS];
    logic [HOLD_W-1:0]       hold_nxt  [PG_NUM_PORTS];
    logic [PG_NUM_PORTS-1:0] flr_hit;
    logic                    flr_bad;
    logic [PG_NUM_PORTS-1:0] grant;
    logic                    grant_any;
    logic [10:0]             grant_vf;
    logic [PG_NUM_PORTS-1:0] active_nxt;

`ifdef PG_FLR_TIMEOUT_EN
    localparam int                 DRAIN_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_MAX  = DRAIN_W'(DRAIN_TIMEOUT);

    logic [DRAIN_W-1:0]      drain_cnt [PG_NUM_PORTS];
    logic [DRAIN_W-1:0]      drain_nxt [PG_NUM_PORTS];
    logic [PG_NUM_PORTS-1:0] to_hit;
`endif

    // Decode the FLR strobe into a per-port hit vector and an out-of-range flag.
    always_comb begin
        flr_bad = i_flr_rcvd_vf & ((i_flr_rcvd_vf_num == 11'd0) |
                                   (i_flr_rcvd_vf_num > NUM_PORTS_VF));
        for (int p = 0; p < PG_NUM_PORTS; p++) begin
            flr_hit[p] = i_flr_rcvd_vf & (i_flr_rcvd_vf_num == 11'(p + 1));
        end
    end

    // Fixed-priority completion arbiter; scanning downwards lets the lowest index win.
    always_comb begin
        grant     = {PG_NUM_PORTS{1'b0}};
        grant_any = 1'b0;
        grant_vf  = 11'd0;
        for (int p = PG_NUM_PORTS - 1; p >= 0; p--) begin
            if (state[p] == ST_CMPL) begin
                grant     = {PG_NUM_PORTS{1'b0}};
                grant[p]  = 1'b1;
                grant_any = 1'b1;
                grant_vf  = 11'(p + 1);
            end else begin
                grant_vf = grant_vf;
            end
        end
    end

    // Per-port next-state: a new FLR always restarts the hold, otherwise advance the sequence.
    always_comb begin
        for (int p = 0; p < PG_NUM_PORTS; p++) begin
            state_nxt[p] = state[p];
            hold_nxt[p]  = hold_cnt[p];
`ifdef PG_FLR_TIMEOUT_EN
            drain_nxt[p] = drain_cnt[p];
            to_hit[p]    = 1'b0;
`endif
            if (flr_hit[p]) begin
                // Covers duplicates too: an FLR landing in CMPL still lets the grant
                // complete, and an ungranted completion merges into the new sequence.
                state_nxt[p] = ST_ASSERT;
                hold_nxt[p]  = {HOLD_W{1'b0}};
            end else begin
                case (state[p])
                    ST_IDLE: begin
                        state_nxt[p] = ST_IDLE;
                    end
                    ST_ASSERT: begin
                        if (hold_cnt[p] == HOLD_LAST) begin
                            state_nxt[p] = ST_DRAIN;
`ifdef PG_FLR_TIMEOUT_EN
                            drain_nxt[p] = {DRAIN_W{1'b0}};
`endif
                        end else if (hold_cnt[p] != HOLD_MAX) begin
                            hold_nxt[p] = hold_cnt[p] + HOLD_W'(1);
                        end else begin
                            hold_nxt[p] = hold_cnt[p];
                        end
                    end
                    ST_DRAIN: begin
                        if (i_port_idle[p]) begin
                            state_nxt[p] = ST_CMPL;
                        end
`ifdef PG_FLR_TIMEOUT_EN
                        else if (drain_cnt[p] == DRAIN_LAST) begin
                            state_nxt[p] = ST_CMPL;
                            to_hit[p]    = 1'b1;
                        end else if (drain_cnt[p] != DRAIN_MAX) begin
                            drain_nxt[p] = drain_cnt[p] + DRAIN_W'(1);
                        end else begin
                            drain_nxt[p] = drain_cnt[p];
                        end
`else
                        else begin
                            state_nxt[p] = ST_DRAIN;
                        end
`endif
                    end
                    ST_CMPL: begin
                        if (grant[p]) begin
                            state_nxt[p] = ST_IDLE;
                        end else begin
                            state_nxt[p] = ST_CMPL;
                        end
                    end
                    default: begin
                        state_nxt[p] = ST_IDLE;
                    end
                endcase
            end
            active_nxt[p] = (state_nxt[p] != ST_IDLE);
        end
    end

    // State, counters and registered outputs; port resets follow the next state so they drop right after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < PG_NUM_PORTS; p++) begin
                state[p]    <= ST_IDLE;
                hold_cnt[p] <= {HOLD_W{1'b0}};
`ifdef PG_FLR_TIMEOUT_EN
                drain_cnt[p] <= {DRAIN_W{1'b0}};
`endif
            end
            o_port_rst_n      <= {PG_NUM_PORTS{1'b0}};
            o_flr_cmpl_vld    <= 1'b0;
            o_flr_cmpl_vf_num <= 11'd0;
            o_flr_busy        <= 1'b0;
            o_flr_err         <= 1'b0;
            o_drain_timeout   <= 1'b0;
        end else begin
            for (int p = 0; p < PG_NUM_PORTS; p++) begin
                state[p]    <= state_nxt[p];
                hold_cnt[p] <= hold_nxt[p];
`ifdef PG_FLR_TIMEOUT_EN
                drain_cnt[p] <= drain_nxt[p];
`endif
            end
            o_port_rst_n      <= ~(active_nxt | {PG_NUM_PORTS{i_pr_reset}});
            o_flr_cmpl_vld    <= grant_any;
            o_flr_cmpl_vf_num <= grant_vf;
            o_flr_busy        <= |active_nxt;
            o_flr_err         <= flr_bad;
`ifdef PG_FLR_TIMEOUT_EN
            o_drain_timeout   <= |to_hit;
`else
            o_drain_timeout   <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pg_port_flr_ctrl.sv
// tb_pg_port_flr_ctrl: scoreboard bench for pg_port_flr_ctrl (3 ports, hold 4,
// drain timeout 8). A reference model advances once per driven cycle and
// queues the expected status outputs and completions. A separate monitor pops
// and compares those entries after each clock edge.
module tb_pg_port_flr_ctrl;

    localparam int N = 3;
    localparam int H = 4;
    localparam int T = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_flr_rcvd_vf;
    logic [10:0]   i_flr_rcvd_vf_num;
    logic [N-1:0]  i_port_idle;
    logic          i_pr_reset;
    logic [N-1:0]  o_port_rst_n;
    logic          o_flr_cmpl_vld;
    logic [10:0]   o_flr_cmpl_vf_num;
    logic          o_flr_busy;
    logic          o_flr_err;
    logic          o_drain_timeout;

    pg_port_flr_ctrl #(
        .PG_NUM_PORTS    (N),
        .RST_HOLD_CYCLES (H),
        .DRAIN_TIMEOUT   (T)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_flr_rcvd_vf     (i_flr_rcvd_vf),
        .i_flr_rcvd_vf_num (i_flr_rcvd_vf_num),
        .i_port_idle       (i_port_idle),
        .i_pr_reset        (i_pr_reset),
        .o_port_rst_n      (o_port_rst_n),
        .o_flr_cmpl_vld    (o_flr_cmpl_vld),
        .o_flr_cmpl_vf_num (o_flr_cmpl_vf_num),
        .o_flr_busy        (o_flr_busy),
        .o_flr_err         (o_flr_err),
        .o_drain_timeout   (o_drain_timeout)
    );

    always #5 clk = ~clk;

    // Edge counter: value k means k rising edges have happened.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [N-1:0] rst_n;
        logic         busy;
        logic         err;
        logic         to;
    } stat_t;

    typedef struct {
        int          cyc;
        logic [10:0] vf;
    } cmpl_t;

    stat_t stat_q[$];
    cmpl_t cmpl_q[$];

    // Reference model: per port an outstanding-FLR flag, a "drain finished" flag,
    // and the absolute cycle at which its drain phase begins.
    bit act      [N];
    bit rdy      [N];
    int drain_at [N];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic model_clear();
        for (int p = 0; p < N; p++) begin
            act[p]      = 1'b0;
            rdy[p]      = 1'b0;
            drain_at[p] = 0;
        end
        stat_q.delete();
        cmpl_q.delete();
    endtask

    function automatic bit model_busy();
        bit b = 1'b0;
        for (int p = 0; p < N; p++) b |= act[p];
        return b;
    endfunction

    // One cycle of the rules: the grant goes to the lowest drained port, drains finish on idle
    // (or after T cycles with the timeout), and a valid FLR re-arms its port.
    task automatic model_step(input logic flr, input logic [10:0] vf,
                              input logic [N-1:0] idle, input logic pr);
        int    g;
        int    hit;
        logic  to_pulse;
        stat_t s;
        cmpl_t c;
        g = -1;
        for (int p = 0; p < N; p++) if (g < 0 && rdy[p]) g = p;
        hit = (flr && vf >= 11'd1 && vf <= 11'(N)) ? int'(vf) - 1 : -1;
        to_pulse = 1'b0;
        if (g >= 0) begin
            c.cyc = cyc + 1;
            c.vf  = 11'(g + 1);
            cmpl_q.push_back(c);
            act[g] = 1'b0;
            rdy[g] = 1'b0;
        end
        for (int p = 0; p < N; p++) begin
            if (p != hit && act[p] && !rdy[p] && cyc >= drain_at[p]) begin
                if (idle[p]) rdy[p] = 1'b1;
`ifdef PG_FLR_TIMEOUT_EN
                else if (cyc == drain_at[p] + T - 1) begin
                    rdy[p]   = 1'b1;
                    to_pulse = 1'b1;
                end
`endif
            end
        end
        if (hit >= 0) begin
            act[hit]      = 1'b1;
            rdy[hit]      = 1'b0;
            drain_at[hit] = cyc + 1 + H;
        end
        s.cyc  = cyc + 1;
        for (int p = 0; p < N; p++) s.rst_n[p] = !(act[p] || pr);
        s.busy = model_busy();
        s.err  = flr && (hit < 0);
        s.to   = to_pulse;
        stat_q.push_back(s);
    endtask

    task automatic drive(input logic flr, input logic [10:0] vf,
                         input logic [N-1:0] idle, input logic pr);
        i_flr_rcvd_vf     = flr;
        i_flr_rcvd_vf_num = vf;
        i_port_idle       = idle;
        i_pr_reset        = pr;
        model_step(flr, vf, idle, pr);
    endtask

    task automatic step(input logic flr, input logic [10:0] vf,
                        input logic [N-1:0] idle, input logic pr);
        @(negedge clk);
        drive(flr, vf, idle, pr);
    endtask

    // Asynchronous reset in mid-cycle: outputs must clear at once and in-flight FLRs vanish.
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #2;
        reset             = 1'b1;
        i_flr_rcvd_vf     = 1'b0;
        i_flr_rcvd_vf_num = 11'd0;
        i_pr_reset        = 1'b0;
        #1;
        chk("async_rst_n", 32'(o_port_rst_n), 32'd0);
        chk("async_busy", 32'(o_flr_busy), 32'd0);
        model_clear();
        repeat (ncyc) begin
            @(posedge clk);
            #1;
            chk("in_reset_vld", 32'(o_flr_cmpl_vld), 32'd0);
            chk("in_reset_rst_n", 32'(o_port_rst_n), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 11'd0, {N{1'b1}}, 1'b0);
    endtask

    // Monitor: pops the status entry for every edge and a completion entry whenever the DUT completes.
    initial begin : monitor
        stat_t s;
        cmpl_t c;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (stat_q.size() > 0) begin
                    s = stat_q.pop_front();
                    chk("rst_n", 32'(o_port_rst_n), 32'(s.rst_n));
                    chk("busy", 32'(o_flr_busy), 32'(s.busy));
                    chk("flr_err", 32'(o_flr_err), 32'(s.err));
                    chk("drain_timeout", 32'(o_drain_timeout), 32'(s.to));
                end
                if (o_flr_cmpl_vld) begin
                    if (cmpl_q.size() == 0) begin
                        chk("cmpl_unexpected", 32'(o_flr_cmpl_vld), 32'd0);
                    end else begin
                        c = cmpl_q.pop_front();
                        chk("cmpl_cycle", 32'(cyc), 32'(c.cyc));
                        chk("cmpl_vf_num", 32'(o_flr_cmpl_vf_num), 32'(c.vf));
                    end
                end else if (cmpl_q.size() > 0 && cmpl_q[0].cyc <= cyc) begin
                    c = cmpl_q.pop_front();
                    chk("cmpl_missing", 32'(o_flr_cmpl_vld), 32'd1);
                end
            end
        end
    end

    initial begin : stimulus
        logic         f;
        logic [10:0]  v;
        logic [N-1:0] id;
        logic         pr;
        int           pr_left;
        int           guard;

        reset             = 1'b1;
        i_flr_rcvd_vf     = 1'b0;
        i_flr_rcvd_vf_num = 11'd0;
        i_port_idle       = {N{1'b1}};
        i_pr_reset        = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_n", 32'(o_port_rst_n), 32'd0);
        chk("reset_vld", 32'(o_flr_cmpl_vld), 32'd0);
        chk("reset_vf_num", 32'(o_flr_cmpl_vf_num), 32'd0);
        chk("reset_busy", 32'(o_flr_busy), 32'd0);
        chk("reset_err", 32'(o_flr_err), 32'd0);
        chk("reset_timeout", 32'(o_drain_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // Single FLR on an idle port: completion H+3 cycles after the strobe.
        step(1'b1, 11'd1, {N{1'b1}}, 1'b0);
        repeat (10) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // Back-to-back FLRs for VF1 and VF2.
        step(1'b1, 11'd1, {N{1'b1}}, 1'b0);
        step(1'b1, 11'd2, {N{1'b1}}, 1'b0);
        repeat (10) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // Out-of-range VF numbers.
        step(1'b1, 11'd0, {N{1'b1}}, 1'b0);
        step(1'b1, 11'd4, {N{1'b1}}, 1'b0);
        step(1'b1, 11'h7FF, {N{1'b1}}, 1'b0);
        repeat (3) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // Duplicate FLR during drain, then let the port go idle.
        step(1'b1, 11'd1, 3'b110, 1'b0);
        repeat (6) step(1'b0, 11'd0, 3'b110, 1'b0);
        step(1'b1, 11'd1, 3'b110, 1'b0);
        repeat (12) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // Contention, with an ungranted duplicate merged on the losing port.
        step(1'b1, 11'd1, 3'b100, 1'b0);
        step(1'b1, 11'd2, 3'b100, 1'b0);
        repeat (8) step(1'b0, 11'd0, 3'b100, 1'b0);
        step(1'b0, 11'd0, {N{1'b1}}, 1'b0);
        step(1'b1, 11'd2, {N{1'b1}}, 1'b0);
        repeat (12) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // Duplicate FLR in the very cycle the port is granted.
        step(1'b1, 11'd2, {N{1'b1}}, 1'b0);
        repeat (5) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);
        step(1'b1, 11'd2, {N{1'b1}}, 1'b0);
        repeat (10) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // PR reset held for 10 cycles with no FLR.
        repeat (10) step(1'b0, 11'd0, {N{1'b1}}, 1'b1);
        repeat (2) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // Drain with idle held low (times out only when the timeout is built in).
        step(1'b1, 11'd3, 3'b011, 1'b0);
        repeat (20) step(1'b0, 11'd0, 3'b011, 1'b0);
        repeat (5) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // Asynchronous reset in the middle of the hold phase.
        step(1'b1, 11'd2, {N{1'b1}}, 1'b0);
        step(1'b0, 11'd0, {N{1'b1}}, 1'b0);
        do_reset(2);
        repeat (10) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);

        // Randomized traffic.
        pr_left = 0;
        for (int i = 0; i < 1500; i++) begin
            f = ($urandom_range(0, 4) == 0);
            v = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(0, 2047))
                                             : 11'($urandom_range(0, N + 1));
            for (int b = 0; b < N; b++) id[b] = ($urandom_range(0, 3) != 0);
            if (pr_left == 0 && $urandom_range(0, 80) == 0) pr_left = $urandom_range(1, 6);
            pr = (pr_left > 0);
            if (pr_left > 0) pr_left--;
            step(f, v, id, pr);
            if (i == 700) do_reset(2);
        end

        // Let every outstanding FLR complete.
        guard = 0;
        while ((model_busy() || cmpl_q.size() > 0) && guard < 200) begin
            step(1'b0, 11'd0, {N{1'b1}}, 1'b0);
            guard++;
        end
        repeat (3) step(1'b0, 11'd0, {N{1'b1}}, 1'b0);
        @(posedge clk);
        #2;
        chk("final_busy", 32'(o_flr_busy), 32'd0);
        chk("final_rst_n", 32'(o_port_rst_n), 32'(7));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
